// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer states, instruction memory default depth,
// and the jump/branch opcodes used by decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int unsigned IMEM_DEPTH_DEFAULT = 16;

  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_BEQ = 6'h04;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection (jump > branch > sequential) and range check
// against the instruction memory depth.
module next_pc_calc #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned PC_W       = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  output logic [PC_W-1:0] target,
  output logic            out_of_range
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] offset_ext;

  assign seq_pc     = pc + PC_W'(1);
  assign offset_ext = {{(PC_W-16){branch_offset[15]}}, branch_offset};

  always_comb begin
    target = seq_pc;
    if (jump) begin
      target = {seq_pc[PC_W-1:26], jump_target};
    end else if (branch_taken) begin
      target = seq_pc + offset_ext;
    end
  end

  assign out_of_range = |target[PC_W-1:AW];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / next-PC sequencer with BOOT/RUN/HALT control and retire
// counter. Define PC_OOB_TRAP_EN to trap out-of-range fetches instead of wrapping.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int unsigned PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  output logic [PC_W-1:0] index,
  output logic [PC_W-1:0] pc_plus1,
  output logic            instr_valid,
  output logic [1:0]      state,
  output logic            trap,
  output logic [31:0]     instr_count
);

  localparam logic [PC_W-1:0] ADDR_MASK = PC_W'(IMEM_DEPTH - 1);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] index_q, index_d;
  logic            trap_q, trap_d;
  logic [31:0]     count_q, count_d;
  logic [PC_W-1:0] target;
  logic            out_of_range;

  next_pc_calc #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .PC_W      (PC_W)
  ) u_next_pc (
    .pc           (index_q),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .target       (target),
    .out_of_range (out_of_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      index_q <= '0;
      trap_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      trap_q  <= trap_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    trap_d      = trap_q;
    count_d     = count_q;
    instr_valid = 1'b0;
    case (state_q)
      RUN: begin
        instr_valid = !stall && !halt_req;
        if (!stall) begin
          if (halt_req) begin
            state_d = HALT;
          end else begin
            count_d = count_q + 32'd1;
`ifdef PC_OOB_TRAP_EN
            // The trapping instruction still retires; PC stays on it for inspection.
            if (out_of_range) begin
              trap_d  = 1'b1;
              state_d = HALT;
            end else begin
              index_d = target;
            end
`else
            index_d = out_of_range ? (target & ADDR_MASK) : target;
`endif
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          if (trap_q) begin
            index_d = '0;
            trap_d  = 1'b0;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign index       = index_q;
  assign pc_plus1    = index_q + PC_W'(1);
  assign state       = state_q;
  assign trap        = trap_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, mid-run reset,
// then randomized stimulus against a spec-level reference model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 16;
`ifdef PC_OOB_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, halt_req, resume, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] index, pc_plus1, instr_count;
  logic        instr_valid, trap;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_sequencer #(.IMEM_DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .index(index), .pc_plus1(pc_plus1),
    .instr_valid(instr_valid), .state(state), .trap(trap), .instr_count(instr_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: states as plain integers 0=BOOT 1=RUN 2=HALT
  logic [31:0] m_pc, m_cnt;
  int          m_st;
  logic        m_trap;
  logic        last_valid;

  typedef struct {
    logic        st, hr, rs, br;
    logic [15:0] off;
    logic        j;
    logic [25:0] jt;
    logic        ev;
    logic [31:0] ei;
    logic [1:0]  es;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic hr, input logic rs, input logic br,
                     input logic [15:0] off, input logic j, input logic [25:0] jt,
                     input logic ev, input logic [31:0] ei, input logic [1:0] es);
    vec_t v;
    v.st = st; v.hr = hr; v.rs = rs; v.br = br; v.off = off;
    v.j = j; v.jt = jt; v.ev = ev; v.ei = ei; v.es = es;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_st = 0; m_trap = 1'b0;
  endtask

  function automatic logic model_valid();
    return (m_st == 1) && !stall && !halt_req;
  endfunction

  task automatic model_step();
    logic [31:0] p1, tgt;
    case (m_st)
      1: if (!stall) begin
        if (halt_req) m_st = 2;
        else begin
          m_cnt = m_cnt + 1;
          p1 = m_pc + 1;
          if (jump) tgt = (p1 & 32'hFC00_0000) | {6'b0, jump_target};
          else if (branch_taken) tgt = p1 + 32'($signed(branch_offset));
          else tgt = p1;
          if (tgt >= DEPTH) begin
            if (TRAP_EN) begin m_trap = 1'b1; m_st = 2; end
            else m_pc = tgt % DEPTH;
          end else m_pc = tgt;
        end
      end
      2: if (resume) begin
        if (m_trap) begin m_pc = 0; m_trap = 1'b0; end
        m_st = 1;
      end
      default: m_st = 1;
    endcase
  endtask

  // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
  task automatic cycle(input string tag);
    #4;
    last_valid = instr_valid;
    chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, model_valid()});
    model_step();
    @(posedge clk);
    #1;
    chk({tag, " index"}, index, m_pc);
    chk({tag, " state"}, {30'b0, state}, m_st);
    chk({tag, " trap"}, {31'b0, trap}, {31'b0, m_trap});
    chk({tag, " instr_count"}, instr_count, m_cnt);
    chk({tag, " pc_plus1"}, pc_plus1, m_pc + 1);
  endtask

  task automatic idle_inputs();
    stall = 0; halt_req = 0; resume = 0; branch_taken = 0; jump = 0;
    branch_offset = '0; jump_target = '0;
  endtask

  initial begin
    // st hr rs br off j jt | valid index_after state_after
    add(0,0,0,0,16'd0,0,26'd0, 0,0,1);   // BOOT cycle, no advance
    add(0,0,0,0,16'd0,0,26'd0, 1,1,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,2,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,3,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,4,1);
    add(1,0,0,0,16'd0,0,26'd0, 0,4,1);   // stall x3
    add(1,0,0,0,16'd0,0,26'd0, 0,4,1);
    add(1,0,0,0,16'd0,0,26'd0, 0,4,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,5,1);
    add(0,0,0,1,16'd1,0,26'd0, 1,7,1);   // branch +1 from 5
    add(0,0,0,1,16'd3,1,26'd8, 1,8,1);   // jump beats branch
    add(0,0,0,0,16'd0,1,26'd0, 1,0,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,1,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,2,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,3,1);
    add(0,1,0,1,16'd5,0,26'd0, 0,3,2);   // halt discards branch
    add(0,0,0,1,16'd2,1,26'd9, 0,3,2);
    add(0,0,1,0,16'd0,0,26'd0, 0,3,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,4,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,5,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,6,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,7,1);
`ifdef PC_OOB_TRAP_EN
    add(0,0,0,1,16'd10,0,26'd0, 1,7,2);  // 18 out of range -> trap
    add(0,0,1,0,16'd0,0,26'd0, 0,0,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,1,1);
    add(0,0,0,1,16'hFFFF,0,26'd0, 1,1,1);
`else
    add(0,0,0,1,16'd10,0,26'd0, 1,2,1);  // 18 mod 16
    add(0,0,1,0,16'd0,0,26'd0, 1,3,1);
    add(0,0,0,0,16'd0,0,26'd0, 1,4,1);
    add(0,0,0,1,16'hFFFF,0,26'd0, 1,4,1);
`endif

    idle_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    chk("reset index", index, 0);
    chk("reset state", {30'b0, state}, 0);
    chk("reset instr_valid", {31'b0, instr_valid}, 0);
    chk("reset trap", {31'b0, trap}, 0);
    chk("reset instr_count", instr_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].st; halt_req = tbl[i].hr; resume = tbl[i].rs;
      branch_taken = tbl[i].br; branch_offset = tbl[i].off;
      jump = tbl[i].j; jump_target = tbl[i].jt;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_valid", i), {31'b0, last_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d tbl_index", i), index, tbl[i].ei);
      chk($sformatf("vec%0d tbl_state", i), {30'b0, state}, {30'b0, tbl[i].es});
    end

    // Asynchronous reset in the middle of a cycle
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst index", index, 0);
    chk("async rst state", {30'b0, state}, 0);
    chk("async rst instr_count", instr_count, 0);
    chk("async rst instr_valid", {31'b0, instr_valid}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 800; i++) begin
      stall = ($urandom % 8) == 0;
      halt_req = ($urandom % 16) == 0;
      resume = ($urandom % 3) == 0;
      jump = ($urandom % 6) == 0;
      jump_target = 26'($urandom_range(0, 20));
      branch_taken = ($urandom % 4) == 0;
      if ($urandom % 2) branch_offset = 16'($urandom_range(0, 16)) - 16'd8;
      else branch_offset = 16'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
